// File: rtl/argon_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : argon_alu_seq                                                |
// | Description : Bus-attached ALU with operand/flag/opcode latches, a         |
// |               start/busy/done handshake and a shift-add multiplier.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module argon_alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_bus,
    output logic [WIDTH-1:0] o_bus,
    output logic             o_bus_valid,
    input  logic             i_latchA,
    input  logic             i_latchB,
    input  logic             i_latchF,
    input  logic             i_latchOp,
    input  logic             i_start,
    input  logic             i_outputY,
    input  logic             i_outputF,
    output logic             o_busy,
    output logic             o_done
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SBC  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LSH  = 4'hA;
    localparam logic [3:0] OP_RSH  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_MULH = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q, b_q, y_q, flags_q, mplier_q;
    logic [3:0]           op_q;
    logic                 busy_q, done_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q;
    logic [SHW-1:0]       cnt_q;

    logic [SHW-1:0]       w_shamt;
    logic [WIDTH:0]       w_res, w_rsh;
    logic                 w_v, w_wr_res, w_cmp, w_is_mul, w_eq;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_prod_y, w_flags_res, w_flags_cmp, w_flags_mul;

    assign w_shamt   = b_q[SHW-1:0];
    assign w_is_mul  = MUL_EN && ((op_q == OP_MUL) || (op_q == OP_MULH));
    assign w_eq      = (a_q == b_q);
    assign w_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_prod_y  = (op_q == OP_MULH) ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];

    // All single-cycle results are formed WIDTH+1 wide; bit WIDTH is the carry/borrow.
    always_comb begin
        w_res    = '0;
        w_rsh    = '0;
        w_v      = 1'b0;
        w_wr_res = 1'b1;
        w_cmp    = 1'b0;
        case (op_q)
            OP_ADD: begin
                w_res = {1'b0, a_q} + {1'b0, b_q};
                w_v   = (a_q[MSB] == b_q[MSB]) && (w_res[MSB] != a_q[MSB]);
            end
            OP_ADC: begin
                w_res = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, flags_q[0]};
                w_v   = (a_q[MSB] == b_q[MSB]) && (w_res[MSB] != a_q[MSB]);
            end
            OP_SBC: begin
                w_res = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, flags_q[0]};
                w_v   = (a_q[MSB] != b_q[MSB]) && (w_res[MSB] != a_q[MSB]);
            end
            OP_INC: begin
                w_res = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
                w_v   = ~a_q[MSB] & w_res[MSB];
            end
            OP_DEC: begin
                w_res = {1'b0, a_q} - {{WIDTH{1'b0}}, 1'b1};
                w_v   = a_q[MSB] & ~w_res[MSB];
            end
            OP_NAND: w_res = {1'b0, ~(a_q & b_q)};
            OP_AND:  w_res = {1'b0, a_q & b_q};
            OP_OR:   w_res = {1'b0, a_q | b_q};
            OP_NOR:  w_res = {1'b0, ~(a_q | b_q)};
            OP_XOR:  w_res = {1'b0, a_q ^ b_q};
            OP_LSH:  w_res = {1'b0, a_q} << w_shamt;
            OP_RSH: begin
                // A guard bit below A catches the last bit shifted out.
                w_rsh = {a_q, 1'b0} >> w_shamt;
                w_res = {w_rsh[0], w_rsh[WIDTH:1]};
            end
            OP_CMP: begin
                w_wr_res = 1'b0;
                w_cmp    = 1'b1;
            end
            default: w_wr_res = 1'b0;
        endcase
    end

    always_comb begin
        w_flags_res    = flags_q;
        w_flags_res[0] = w_res[WIDTH];
        w_flags_res[1] = (w_res[WIDTH-1:0] == '0);
        w_flags_res[5] = w_res[MSB];
        w_flags_res[6] = w_v;

        w_flags_cmp    = flags_q;
        w_flags_cmp[1] = w_eq;
        w_flags_cmp[2] = w_eq;
        w_flags_cmp[3] = (a_q > b_q);
        w_flags_cmp[4] = (a_q < b_q);

        w_flags_mul    = flags_q;
        w_flags_mul[0] = |w_acc_nxt[2*WIDTH-1:WIDTH];
        w_flags_mul[1] = (w_prod_y == '0);
        w_flags_mul[5] = w_prod_y[MSB];
        w_flags_mul[6] = 1'b0;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            flags_q  <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_latchA)       a_q     <= i_bus;
                    else if (i_latchB)  b_q     <= i_bus;
                    else if (i_latchF)  flags_q <= i_bus;
                    else if (i_latchOp) op_q    <= i_bus[3:0];
                    else if (i_start) begin
                        if (w_is_mul) begin
                            state_q  <= ST_MUL;
                            busy_q   <= 1'b1;
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, a_q};
                            mplier_q <= b_q;
                            cnt_q    <= '0;
                        end else begin
                            if (w_wr_res) begin
                                y_q     <= w_res[WIDTH-1:0];
                                flags_q <= w_flags_res;
                            end else if (w_cmp) begin
                                flags_q <= w_flags_cmp;
                            end
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= w_acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        y_q     <= w_prod_y;
                        flags_q <= w_flags_mul;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        if (i_outputY)      o_bus = y_q;
        else if (i_outputF) o_bus = flags_q;
        else                o_bus = '0;
    end

    assign o_bus_valid = i_outputY | i_outputF;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule
`default_nettype wire
